// File: rtl/fn_enable_sequencer.sv
// rtl/fn_enable_sequencer.sv - debounced function-switch selector with frame-aligned, blanked enable switching
module fn_enable_sequencer #(
    parameter int N_SW       = 4,
    parameter int DB_BITS    = 16,
    parameter int FRAME_BITS = 6
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] SW_raw,
    output logic [N_SW-1:0] Enable_SW,
    output logic            Frame_Start,
    output logic            Blanking
);

    localparam logic [DB_BITS-1:0]    DB_ONE    = {{(DB_BITS-1){1'b0}}, 1'b1};
    localparam logic [DB_BITS-1:0]    DB_LAST   = {{(DB_BITS-1){1'b1}}, 1'b0};
    localparam logic [FRAME_BITS-1:0] FRAME_ONE = {{(FRAME_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_t;

    logic [N_SW-1:0]       sw_meta;
    logic [N_SW-1:0]       sw_sync;
    logic [N_SW-1:0]       stable;
    logic [DB_BITS-1:0]    db_cnt [N_SW];
    logic [N_SW-1:0]       request;
    logic                  found;
    logic [FRAME_BITS-1:0] frame_cnt;
    logic                  frame_end;
    state_t                state;
    state_t                state_nxt;
    logic [N_SW-1:0]       en_nxt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW_raw;
            sw_sync <= sw_meta;
        end
    end

    // The level is accepted on the edge that would bring the count to DB_MAX.
    for (genvar b = 0; b < N_SW; b++) begin : g_db
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                stable[b] <= 1'b0;
                db_cnt[b] <= '0;
            end else if (sw_sync[b] == stable[b]) begin
                db_cnt[b] <= '0;
            end else if (db_cnt[b] == DB_LAST) begin
                stable[b] <= sw_sync[b];
                db_cnt[b] <= '0;
            end else begin
                db_cnt[b] <= db_cnt[b] + DB_ONE;
            end
        end
    end

    always_comb begin
        request = '0;
        found   = 1'b0;
        for (int i = 0; i < N_SW; i++) begin
            if (stable[i] && !found) begin
                request[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FRAME_ONE;
        end
    end

    assign frame_end = &frame_cnt;

    always_comb begin
        state_nxt = state;
        en_nxt    = Enable_SW;
        if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (request != '0) begin
                        state_nxt = ST_ACTIVE;
                        en_nxt    = request;
                    end
                end
                ST_ACTIVE: begin
                    if (request == '0) begin
                        state_nxt = ST_IDLE;
                        en_nxt    = '0;
                    end else if (request != Enable_SW) begin
                        state_nxt = ST_BLANK;
                        en_nxt    = '0;
                    end
                end
                ST_BLANK: begin
                    if (request != '0) begin
                        state_nxt = ST_ACTIVE;
                        en_nxt    = request;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    en_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            Enable_SW   <= '0;
            Blanking    <= 1'b0;
            Frame_Start <= 1'b0;
        end else begin
            state       <= state_nxt;
            Enable_SW   <= en_nxt;
            Blanking    <= (state_nxt == ST_BLANK);
            Frame_Start <= frame_end;
        end
    end

endmodule

// File: tb/tb_fn_enable_sequencer.sv
// tb/tb_fn_enable_sequencer.sv - self-checking bench for fn_enable_sequencer
module tb_fn_enable_sequencer;

    logic       sysclk;
    logic       rst_n;
    logic [3:0] SW_raw;
    logic [3:0] Enable_SW;
    logic       Frame_Start;
    logic       Blanking;

    int n_tests = 0;
    int n_fail  = 0;

    fn_enable_sequencer #(
        .N_SW      (4),
        .DB_BITS   (4),
        .FRAME_BITS(6)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .SW_raw     (SW_raw),
        .Enable_SW  (Enable_SW),
        .Frame_Start(Frame_Start),
        .Blanking   (Blanking)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Reference: sync is a 2-sample delay, a level is accepted after 15 consecutive
    // differing samples, and the enable only moves at frame boundaries.
    logic [3:0] m_s1, m_s2, m_stable, m_en;
    logic [3:0] m_hist [15];
    logic       m_bl, m_fs;
    int         m_cyc;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_en = '0;
        m_bl = 1'b0; m_fs = 1'b0; m_cyc = 0;
        for (int k = 0; k < 15; k++) m_hist[k] = '0;
    endtask

    task automatic model_edge();
        logic [3:0] req, all_diff;
        logic       fe;
        fe  = (m_cyc % 64) == 63;
        req = m_stable & (~m_stable + 4'd1);
        for (int k = 14; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        all_diff = 4'hF;
        for (int k = 0; k < 15; k++) all_diff = all_diff & (m_hist[k] ^ m_stable);
        m_stable = m_stable ^ all_diff;
        m_s2 = m_s1;
        m_s1 = SW_raw;
        if (fe) begin
            if (m_en == 4'd0) begin
                m_en = req;
                m_bl = 1'b0;
            end else if (req != m_en) begin
                m_bl = (req != 4'd0);
                m_en = 4'd0;
            end
        end
        m_fs = fe;
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_edge();
        #1;
        chk("model_enable", 32'(Enable_SW), 32'(m_en));
        chk("model_frame_start", 32'(Frame_Start), 32'(m_fs));
        chk("model_blanking", 32'(Blanking), 32'(m_bl));
        chk("onehot", 32'($countones(Enable_SW) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_outs(input string name, input logic [3:0] en, input logic bl, input logic fs);
        chk({name, "_enable"}, 32'(Enable_SW), 32'(en));
        chk({name, "_blanking"}, 32'(Blanking), 32'(bl));
        chk({name, "_frame_start"}, 32'(Frame_Start), 32'(fs));
    endtask

    task automatic do_reset(input int n);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_reset", 4'b0000, 1'b0, 1'b0);
        repeat (n) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] en;
        logic       bl;
        logic       fs;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{4'b0000, 10, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 54, 4'b0100, 1'b0, 1'b1};
        vecs[2]  = '{4'b0001, 64, 4'b0000, 1'b1, 1'b1};
        vecs[3]  = '{4'b0001, 64, 4'b0001, 1'b0, 1'b1};
        vecs[4]  = '{4'b1010, 64, 4'b0000, 1'b1, 1'b1};
        vecs[5]  = '{4'b1010, 64, 4'b0010, 1'b0, 1'b1};
        vecs[6]  = '{4'b1000, 64, 4'b0000, 1'b1, 1'b1};
        vecs[7]  = '{4'b1000, 64, 4'b1000, 1'b0, 1'b1};
        vecs[8]  = '{4'b0000, 64, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{4'b1000, 64, 4'b1000, 1'b0, 1'b1};
        vecs[10] = '{4'b0100, 20, 4'b1000, 1'b0, 1'b0};
        vecs[11] = '{4'b1000, 44, 4'b1000, 1'b0, 1'b1};
        vecs[12] = '{4'b0000, 64, 4'b0000, 1'b0, 1'b1};

        rst_n  = 1'b0;
        SW_raw = 4'b0000;
        model_reset();
        repeat (3) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        check_outs("reset", 4'b0000, 1'b0, 1'b0);

        for (int v = 0; v < 13; v++) begin
            SW_raw = vecs[v].raw;
            run(vecs[v].hold);
            check_outs($sformatf("vec%0d", v), vecs[v].en, vecs[v].bl, vecs[v].fs);
        end

        // Bounce on bit 1: 5-cycle segments never satisfy the debounce window.
        for (int seg = 0; seg < 20; seg++) begin
            SW_raw = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
            run(5);
        end
        SW_raw = 4'b0010;
        run(27);
        check_outs("bounce_before", 4'b0000, 1'b0, 1'b0);
        run(1);
        check_outs("bounce_enable", 4'b0010, 1'b0, 1'b1);

        SW_raw = 4'b0100;
        run(64);
        check_outs("switch_blank", 4'b0000, 1'b1, 1'b1);
        run(64);
        check_outs("switch_active", 4'b0100, 1'b0, 1'b1);
        run(20);
        do_reset(3);
        run(63);
        check_outs("post_reset_wait", 4'b0000, 1'b0, 1'b0);
        run(1);
        check_outs("post_reset_enable", 4'b0100, 1'b0, 1'b1);

        for (int r = 0; r < 120; r++) begin
            SW_raw = 4'($urandom_range(0, 15));
            run($urandom_range(1, 40));
        end
        do_reset(2);
        for (int r = 0; r < 40; r++) begin
            SW_raw = 4'($urandom_range(0, 15));
            run($urandom_range(10, 90));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fn_enable_sequencer.md
# fn_enable_sequencer

Conditions the raw function-select slide switches and drives the one-hot `Enable_SW` lines consumed by the waveform generator stages (square, solid-square, etc.). Each switch is synchronised and debounced, and the lowest-index active switch is selected. Enable changes are applied only on 64-cycle PWM frame boundaries, with one fully dark frame between functions, so no downstream PWM output ever emits a runt pulse.

## Interface
- `N_SW`, 4: number of function switches / enable lines.
- `DB_BITS`, 16: debounce counter width; a switch must hold a new level for DB_MAX = 2^DB_BITS − 1 consecutive cycles.
- `FRAME_BITS`, 6: PWM frame counter width; frame length = 2^FRAME_BITS cycles (64).
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SW_raw`  in  N_SW  raw, asynchronous, bouncing switch inputs.
- `Enable_SW`  out  N_SW  registered one-hot (or all-zero) generator enables.
- `Frame_Start`  out  1  registered one-cycle strobe marking the first cycle of each frame.
- `Blanking`  out  1  registered; high while in the BLANK state.

## Operation
- Synchroniser: two flops per bit, `SW_raw` → `sw_sync`.
- Debounce, per bit: `stable` register plus a DB_BITS counter.
  - If `sw_sync == stable`, the counter clears.
  - Otherwise the counter increments. When it reaches DB_MAX, `stable <= sw_sync` and the counter clears on the same edge.
  - Any bounce back to the `stable` level before DB_MAX restarts the count.
- Request (combinational from `stable`): one-hot of the lowest-index set bit. All-zero if no bit is set.
- Frame counter: free-running FRAME_BITS bits, wraps from max to 0. `frame_end` = (counter == max).
- FSM (IDLE, ACTIVE, BLANK). Transitions are evaluated only on edges where `frame_end` is high; otherwise the state holds.
  - IDLE, `Enable_SW`=0: request≠0 → ACTIVE, `Enable_SW`<=request. Else stay.
  - ACTIVE: request==`Enable_SW` → stay. request==0 → IDLE, `Enable_SW`<=0. Other nonzero → BLANK, `Enable_SW`<=0.
  - BLANK, `Enable_SW`=0: request≠0 → ACTIVE, `Enable_SW`<=request (the current request, not the one that caused the blank). request==0 → IDLE.
- `Blanking` = (state == BLANK), registered with the state.
- `Enable_SW` is never multi-hot.

## Timing
- Reset values: sync flops 0, `stable` 0, debounce counters 0, frame counter 0, state IDLE, `Enable_SW` 0, `Frame_Start` 0, `Blanking` 0.
- `Frame_Start` is high during the cycle after `frame_end`, i.e. the cycle with frame counter == 0, except the cycle immediately after reset release. The first pulse falls on cycle 64 after reset.
- `Enable_SW` and `Blanking` change only on the edge that produces `Frame_Start`; every change is coincident with `Frame_Start` high.
- Latency from a clean `SW_raw` edge:
  - 2 cycles to `sw_sync`, then DB_MAX cycles to `stable`.
  - Then a wait of 1..64 cycles to the next frame edge.
  - Function-to-function changes add exactly one further frame (64 cycles) of BLANK.
- Request changes in the frame before the boundary: only the value sampled at `frame_end` matters. Intra-frame glitches are ignored.
- A request that returns to the current `Enable_SW` before `frame_end` causes no BLANK.
- Asynchronous reset mid-frame or mid-BLANK: all outputs drop to 0 immediately. After release, operation restarts from IDLE with frame counter 0.

## Test plan
Simulate with `DB_BITS`=4 (DB_MAX=15) and `FRAME_BITS`=6.
- Reset release, `SW_raw`=0000 → `Enable_SW`=0000 and `Blanking`=0 forever; `Frame_Start` pulses at cycles 64, 128, 192.
- Assert `SW_raw`=0100 cleanly at cycle 10 → `stable`=0100 at cycle 27; `Enable_SW`=0100 from cycle 64, coincident with `Frame_Start`.
- Bounce: `SW_raw`[1] toggling every 5 cycles for 100 cycles, then held at 1 → no change until 17 cycles after the final edge; then `Enable_SW`=0010 at the next frame boundary.
- Active on 0100; switch to 0001 → next boundary `Enable_SW`=0000 with `Blanking`=1 for 64 cycles; following boundary `Enable_SW`=0001 with `Blanking`=0.
- Switches 1010 debounced together → `Enable_SW`=0010 (lowest index wins); release bit 1 → BLANK frame, then `Enable_SW`=1000.
- `rst_n` low for 3 cycles in mid-frame while ACTIVE=0100 → `Enable_SW`=0000 asynchronously. After release, with the switch still held, `Enable_SW`=0100 at cycle 64 (DB_MAX+2 < 64).
